// File: rtl/ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// ps2_kbd_rx
//
// PS/2 keyboard receiver. Raw ps2_clk / ps2_data are synchronised into the
// clk domain, 11-bit frames are deframed and checked (start, stop and odd
// parity), and the E0 / F0 prefix bytes are folded into ext / brk flags on
// the following code byte. Decoded key events are buffered in a circular
// FIFO and handed out on a valid/ready handshake.
//
// Parameters
//   FIFO_DEPTH  event FIFO entries (power of 2, >= 2)
//   TIMEOUT     clk cycles without a PS/2 falling edge before a partial
//               frame is aborted (>= 16)
//
// Ports
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   ps2_clk     raw PS/2 clock (asynchronous)
//   ps2_data    raw PS/2 data (asynchronous)
//   out_ready   consumer accepts the head event
//   clr_err     one-cycle pulse clearing overflow and frame_err
//   out_valid   FIFO holds at least one event
//   out_code    scan code of the head event
//   out_brk     head event was preceded by F0 (key release)
//   out_ext     head event was preceded by E0 (extended key)
//   fifo_count  number of stored events
//   overflow    sticky: an event was dropped because the FIFO was full
//   frame_err   sticky: a frame was rejected (start/stop/parity/timeout)
//   busy        a frame is in progress
// ---------------------------------------------------------------------------
module ps2_kbd_rx #(
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 50000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    input  logic                          out_ready,
    input  logic                          clr_err,
    output logic                          out_valid,
    output logic [7:0]                    out_code,
    output logic                          out_brk,
    output logic                          out_ext,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          frame_err,
    output logic                          busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]       LAST_BIT = 4'd10;
    localparam logic [7:0]       CODE_EXT = 8'hE0;
    localparam logic [7:0]       CODE_BRK = 8'hF0;

    // Synchronisers
    logic [2:0]        clk_sync_q,   clk_sync_d;
    logic [1:0]        data_sync_q,  data_sync_d;

    // Deframer
    logic [3:0]        bit_cnt_q,    bit_cnt_d;
    logic [10:0]       shift_q,      shift_d;
    logic [TMR_W-1:0]  timer_q,      timer_d;
    logic              check_q,      check_d;

    // Prefix decoder
    logic              ext_f_q,      ext_f_d;
    logic              brk_f_q,      brk_f_d;
    logic              ev_valid_q,   ev_valid_d;
    logic [9:0]        ev_q,         ev_d;

    // Event FIFO
    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [9:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q,     rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q,     wr_ptr_d;
    logic [CNT_W-1:0]  count_q,      count_d;

    // Status
    logic              overflow_q,   overflow_d;
    logic              frame_err_q,  frame_err_d;
    logic              busy_q,       busy_d;

    // Internal combinational signals
    logic              ps2_fall;
    logic [10:0]       frame_next;
    logic              timeout_hit;
    logic              frame_ok;
    logic              frame_bad;
    logic              push;
    logic              pop;
    logic              drop;

    // Data uses one flop fewer than the clock so that data sync stage 2 is
    // sampled in the same cycle the clock edge is detected (stage 2 vs 3).
    always_comb begin
        clk_sync_d  = {clk_sync_q[1:0], ps2_clk};
        data_sync_d = {data_sync_q[0], ps2_data};
        ps2_fall    = !clk_sync_q[1] && clk_sync_q[2];
    end

    // Deframer. Bits are shifted in at the MSB so that after the stop bit
    // the register holds the frame with the start bit at index 0. The
    // frame is checked one cycle later from the registered shift contents.
    always_comb begin
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        timer_d     = timer_q;
        check_d     = 1'b0;
        timeout_hit = 1'b0;
        frame_next  = {data_sync_q[1], shift_q[10:1]};

        if (ps2_fall) begin
            shift_d = frame_next;
            timer_d = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d = '0;
                check_d   = 1'b1;
            end else begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != '0) begin
            if (timer_q >= TMR_LAST) begin
                timeout_hit = 1'b1;
                bit_cnt_d   = '0;
                timer_d     = '0;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end else begin
            timer_d = '0;
        end
    end

    // Frame check: start = 0, stop = 1, odd parity over data + parity bit.
    always_comb begin
        frame_ok  = check_q && !shift_q[0] && shift_q[10] && (^shift_q[9:1]);
        frame_bad = check_q && !frame_ok;
    end

    // Prefix decoder. E0 and F0 only set flags; any other byte becomes an
    // event carrying the accumulated flags. A rejected or aborted frame
    // forgets any pending prefix so a later byte is not mis-tagged.
    always_comb begin
        ext_f_d    = ext_f_q;
        brk_f_d    = brk_f_q;
        ev_valid_d = 1'b0;
        ev_d       = ev_q;

        if (frame_ok) begin
            if (shift_q[8:1] == CODE_EXT) begin
                ext_f_d = 1'b1;
            end else if (shift_q[8:1] == CODE_BRK) begin
                brk_f_d = 1'b1;
            end else begin
                ev_valid_d = 1'b1;
                ev_d       = {ext_f_q, brk_f_q, shift_q[8:1]};
                ext_f_d    = 1'b0;
                brk_f_d    = 1'b0;
            end
        end

        if (frame_bad || timeout_hit) begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
        end
    end

    // Event FIFO. A full FIFO still accepts an event when the head is
    // popped in the same cycle, since the popped slot is the one reused.
    always_comb begin
        pop      = (count_q != '0) && out_ready;
        push     = ev_valid_q && ((count_q < DEPTH_C) || pop);
        drop     = ev_valid_q && !push;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push) begin
            mem_d[wr_ptr_q] = ev_q;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Sticky status: a new error in the same cycle as clr_err wins.
    always_comb begin
        overflow_d  = (overflow_q  && !clr_err) || drop;
        frame_err_d = (frame_err_q && !clr_err) || frame_bad || timeout_hit;
        busy_d      = (bit_cnt_q != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync_q  <= 3'b111;
            data_sync_q <= 2'b11;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            timer_q     <= '0;
            check_q     <= 1'b0;
            ext_f_q     <= 1'b0;
            brk_f_q     <= 1'b0;
            ev_valid_q  <= 1'b0;
            ev_q        <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            data_sync_q <= data_sync_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            timer_q     <= timer_d;
            check_q     <= check_d;
            ext_f_q     <= ext_f_d;
            brk_f_q     <= brk_f_d;
            ev_valid_q  <= ev_valid_d;
            ev_q        <= ev_d;
            mem_q       <= mem_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // The head entry is masked while empty so the outputs read zero after
    // reset without depending on stale memory contents.
    assign out_valid  = (count_q != '0);
    assign {out_ext, out_brk, out_code} = out_valid ? mem_q[rd_ptr_q] : 10'd0;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign frame_err  = frame_err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// ---------------------------------------------------------------------------
// tb_ps2_kbd_rx
//
// Self-checking bench for ps2_kbd_rx. Frames are driven bit by bit on the
// raw PS/2 pins; a reference model of the prefix/event rules pushes the
// expected events into a scoreboard queue, and a monitor pops and compares
// whenever the DUT hands an event out.
// ---------------------------------------------------------------------------
module tb_ps2_kbd_rx;

    localparam int DEPTH = 4;
    localparam int TMO   = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        out_ready;
    logic        clr_err;
    logic        out_valid;
    logic [7:0]  out_code;
    logic        out_brk;
    logic        out_ext;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        frame_err;
    logic        busy;

    ps2_kbd_rx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .out_ready  (out_ready),
        .clr_err    (clr_err),
        .out_valid  (out_valid),
        .out_code   (out_code),
        .out_brk    (out_brk),
        .out_ext    (out_ext),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          half = 40;
    int          ready_mode = 0;
    int          stop_k = 0;
    int          rise_cyc = 0;
    logic        prev_valid = 1'b0;

    // Reference model state
    logic [9:0]  exp_q [$];
    logic        m_ext = 1'b0;
    logic        m_brk = 1'b0;
    logic        exp_ovf = 1'b0;
    logic        exp_ferr = 1'b0;

    // Pending direct checks, evaluated by the monitor
    string       chk_name_q [$];
    logic [31:0] chk_act_q [$];
    logic [31:0] chk_req_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready driver: 0 = hold low, 1 = hold high, otherwise random
    always begin
        @(posedge clk);
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: scoreboard compare on handshake, plus queued direct checks
    always @(negedge clk) begin
        logic [9:0] exp_ev;
        while (chk_name_q.size() > 0) begin
            string       nm;
            logic [31:0] a;
            logic [31:0] r;
            nm = chk_name_q.pop_front();
            a  = chk_act_q.pop_front();
            r  = chk_req_q.pop_front();
            total++;
            if (a !== r) begin
                bad++;
                $display("[TB] FAIL %s: got %0h required %0h", nm, a, r);
            end
        end
        if (!rst) begin
            if (out_valid && !prev_valid && rise_cyc == 0) rise_cyc = cyc;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL event: got %h required none", {out_ext, out_brk, out_code});
                end else begin
                    exp_ev = exp_q.pop_front();
                    if ({out_ext, out_brk, out_code} !== exp_ev) begin
                        bad++;
                        $display("[TB] FAIL event: got %h required %h", {out_ext, out_brk, out_code}, exp_ev);
                    end
                end
            end
        end
        prev_valid = out_valid;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: got no finish required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] req);
        chk_name_q.push_back(nm);
        chk_act_q.push_back(act);
        chk_req_q.push_back(req);
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] makeFrame(input logic [7:0] b, input bit bad_par);
        logic p;
        p = ~(^b) ^ bad_par;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Specification-level event rules, applied once per complete frame
    task automatic modelByte(input logic [7:0] b, input bit good);
        if (!good) begin
            exp_ferr = 1'b1;
            m_ext    = 1'b0;
            m_brk    = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() >= DEPTH) exp_ovf = 1'b1;
            else exp_q.push_back({m_ext, m_brk, b});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic driveBits(input logic [10:0] frame, input int first, input int last,
                             input bit model_en, input logic [7:0] b, input bit good);
        for (int i = first; i <= last; i++) begin
            ps2_data = frame[i];
            waitCycles(half);
            ps2_clk = 1'b0;
            if (i == 10) begin
                stop_k = cyc + 1;
                if (model_en) modelByte(b, good);
            end
            waitCycles(half);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par);
        driveBits(makeFrame(b, bad_par), 0, 10, 1'b1, b, !bad_par);
    endtask

    task automatic clrPulse();
        clr_err = 1'b1;
        waitCycles(1);
        clr_err  = 1'b0;
        exp_ovf  = 1'b0;
        exp_ferr = 1'b0;
    endtask

    task automatic waitDrain(input int budget);
        for (int i = 0; i < budget && (exp_q.size() != 0 || fifo_count != 0); i++) waitCycles(1);
        checkOutput("drain", 32'(fifo_count) + 32'(exp_q.size()), 0);
    endtask

    initial begin
        logic [7:0] rb;
        bit         rbad;
        int         r;

        rst      = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        clr_err  = 1'b0;
        waitCycles(3);
        checkOutput("reset_state",
                    {out_valid, out_code, out_brk, out_ext, fifo_count, overflow, frame_err, busy}, 0);
        rst = 1'b0;
        waitCycles(5);

        // Single make code, exact latency and one-cycle handshake
        ready_mode = 0;
        rise_cyc   = 0;
        applyStimulus(8'h1C, 0);
        checkOutput("latency", rise_cyc, stop_k + 4);
        checkOutput("count_1c", 32'(fifo_count), 1);
        ready_mode = 1;
        waitCycles(1);
        ready_mode = 0;
        @(negedge clk);
        checkOutput("valid_drop", 32'(out_valid), 0);
        waitCycles(2);

        // Prefix folding: E0 F0 75 gives a single ext+brk event
        applyStimulus(8'hE0, 0);
        applyStimulus(8'hF0, 0);
        applyStimulus(8'h75, 0);
        checkOutput("count_prefix", 32'(fifo_count), 1);
        checkOutput("head_prefix", {out_ext, out_brk, out_code}, 32'h375);
        ready_mode = 1;
        waitDrain(100);

        // Overflow with FIFO_DEPTH=4
        ready_mode = 0;
        waitCycles(3);
        applyStimulus(8'h16, 0);
        applyStimulus(8'h1E, 0);
        applyStimulus(8'h26, 0);
        applyStimulus(8'h25, 0);
        applyStimulus(8'h2E, 0);
        checkOutput("count_full", 32'(fifo_count), 4);
        checkOutput("overflow_set", 32'(overflow), 1);
        ready_mode = 1;
        waitDrain(100);
        clrPulse();
        checkOutput("overflow_clr", 32'(overflow), 0);

        // Parity error, then a good frame
        ready_mode = 0;
        applyStimulus(8'h1C, 1);
        checkOutput("parity_err", 32'(frame_err), 1);
        checkOutput("parity_noevent", 32'(fifo_count), 0);
        ready_mode = 1;
        applyStimulus(8'h32, 0);
        waitDrain(100);
        clrPulse();

        // Timeout of a partial frame
        driveBits(makeFrame(8'h4D, 0), 0, 4, 1'b0, 8'h4D, 1'b1);
        checkOutput("busy_partial", 32'(busy), 1);
        waitCycles(250);
        checkOutput("busy_timeout", 32'(busy), 0);
        checkOutput("timeout_err", 32'(frame_err), 1);
        clrPulse();
        applyStimulus(8'h4D, 0);
        waitDrain(100);

        // Reset mid-frame with two events buffered
        ready_mode = 0;
        waitCycles(3);
        applyStimulus(8'h1C, 0);
        applyStimulus(8'h32, 0);
        checkOutput("count_two", 32'(fifo_count), 2);
        driveBits(makeFrame(8'h5A, 0), 0, 6, 1'b0, 8'h5A, 1'b1);
        checkOutput("busy_before_rst", 32'(busy), 1);
        rst = 1'b1;
        waitCycles(1);
        rst = 1'b0;
        checkOutput("post_reset",
                    {out_valid, out_code, out_brk, out_ext, fifo_count, overflow, frame_err, busy}, 0);
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        driveBits(makeFrame(8'h5A, 0), 7, 10, 1'b0, 8'h5A, 1'b1);
        waitCycles(TMO + 50);
        checkOutput("resume_noevent", 32'(fifo_count), 0);
        checkOutput("resume_idle", 32'(busy), 0);
        checkOutput("resume_err", 32'(frame_err), 1);
        clrPulse();

        // Randomised traffic against the reference model
        ready_mode = 2;
        for (int n = 0; n < 40; n++) begin
            half = $urandom_range(4, 20);
            r    = $urandom_range(0, 9);
            if (r == 0)      rb = 8'hE0;
            else if (r == 1) rb = 8'hF0;
            else             rb = 8'($urandom_range(0, 255));
            rbad = ($urandom_range(0, 11) == 0);
            applyStimulus(rb, rbad);
            waitCycles($urandom_range(0, 30));
        end
        ready_mode = 1;
        waitDrain(300);
        checkOutput("rand_overflow", 32'(overflow), 32'(exp_ovf));
        checkOutput("rand_frame_err", 32'(frame_err), 32'(exp_ferr));

        waitCycles(2);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ps2_kbd_rx.md
# ps2_kbd_rx

Parametrised PS/2 keyboard receiver, successor to the current keyboard front end. Synchronises raw `ps2_clk`/`ps2_data`, deframes 11-bit frames with start, stop and odd-parity checks, and folds the `E0`/`F0` prefixes into flags. Buffers decoded key events in a FIFO of configurable depth and hands them out on a valid/ready handshake. It replaces the `nextdata_n` pulse interface; the 7-segment display logic consumes `out_code` downstream.

## Interface
- `FIFO_DEPTH`, default 8: event FIFO entries. Must be a power of 2, ≥2.
- `TIMEOUT`, default 50000: `clk` cycles without a PS/2 falling edge before a partial frame is aborted. Must be ≥16.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  raw PS/2 clock, asynchronous.
- `ps2_data`  in  1  raw PS/2 data, asynchronous.
- `out_ready`  in  1  consumer accepts the head event.
- `clr_err`  in  1  one-cycle pulse; clears `overflow` and `frame_err`.
- `out_valid`  out  1  FIFO non-empty.
- `out_code`  out  8  scan code of the head event.
- `out_brk`  out  1  head event was preceded by `F0` (key release).
- `out_ext`  out  1  head event was preceded by `E0` (extended key).
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of stored events.
- `overflow`  out  1  sticky; an event was dropped because the FIFO was full.
- `frame_err`  out  1  sticky; a frame was rejected (start, stop, parity or timeout).
- `busy`  out  1  a frame is in progress (bit count ≠ 0).

## Operation
- Synchronisation: `ps2_clk` passes through a 3-flop chain; `ps2_data` passes through a 2-flop chain aligned with it. A falling edge is sync stage 2 = 0 while stage 3 = 1.
- Deframer: a 4-bit counter runs 0..10 and an 11-bit shift register captures synchronised data on each falling edge.
  - Bit 0 is the start bit, 0.
  - Bits 1-8 are data, LSB first.
  - Bit 9 is odd parity: the XOR of the 8 data bits and the parity bit is 1.
  - Bit 10 is the stop bit, 1.
- Frame check after bit 10:
  - Valid frame: emit byte to the decoder, then counter → 0.
  - Invalid frame: set `frame_err`, discard the byte, clear both prefix flags, counter → 0.
- Timeout: when the counter ≠ 0, a timer counts cycles since the last falling edge. On reaching `TIMEOUT`: counter → 0, set `frame_err`, clear prefix flags. The timer resets on every falling edge.
- Decoder states are held as flags `ext_f` and `brk_f`:
  - byte `E0`: set `ext_f`, no event.
  - byte `F0`: set `brk_f`, no event.
  - Any other byte (including `E1`): push event {ext_f, brk_f, byte}, then clear both flags.
  - `F0` followed by `E0` still yields ext=1, brk=1 on the next code byte.
- FIFO is circular, with pointers wrapping modulo `FIFO_DEPTH`.
  - Push when an event is produced and (count < DEPTH, or a pop happens in the same cycle).
  - Otherwise drop the event and set `overflow`.
  - Pop when `out_valid && out_ready`.
  - Simultaneous push and pop leaves the count unchanged.
  - `out_*` always shows the head entry; the value is don't-care while `out_valid` = 0.
- Sticky flags:
  - `clr_err` clears both flags.
  - If a new error occurs in the same cycle as `clr_err`, the flag stays set.
- Reset: on `rst` = 1 at an edge, all of the following reset.
  - Outputs: `out_valid`=0, `out_code`=0, `out_brk`=0, `out_ext`=0, `fifo_count`=0, `overflow`=0, `frame_err`=0, `busy`=0.
  - Internal state: counter, timer, prefix flags and pointers = 0; sync flops = 1.
  - A frame in progress when reset asserts is discarded with no error flagged.

## Timing
- Latency is measured from edge k, the first rising `clk` edge that samples raw `ps2_clk` = 0 for the stop bit. With the FIFO empty, `out_valid` = 1 after edge k+4.
- `busy` rises 3 cycles after the start bit's raw falling edge is first sampled, and falls 3 cycles after the stop bit's raw falling edge is first sampled.
- Handshake:
  - An event is consumed at the edge where `out_valid && out_ready`.
  - The next entry appears in the following cycle.
  - Throughput is 1 event per cycle.
  - `out_valid` never depends combinationally on `out_ready`.
- `fifo_count` updates at the same edge as the push or pop.
- Minimum supported PS/2 half-period is 4 `clk` cycles.

## Test plan
- Make code `1C` (data 00111000 LSB first, parity 0, stop 1), 40-cycle half-period → `out_code`=1C, `out_brk`=0, `out_ext`=0. `out_valid` rises exactly at k+4; it drops 1 cycle after `out_ready` pulses.
- Frames `E0`,`F0`,`75`, `out_ready`=0 → `fifo_count`=1, event {ext=1, brk=1, 75}; no events for the prefixes.
- `FIFO_DEPTH`=4, `out_ready`=0, send 5 make codes `16`,`1E`,`26`,`25`,`2E` → `fifo_count`=4, `overflow`=1. Draining yields 16,1E,26,25. A `clr_err` pulse then clears `overflow`.
- Frame `1C` with parity bit flipped → no event, `frame_err`=1. A following good `32` frame is delivered normally.
- `TIMEOUT`=200: send 5 bits, stall `ps2_clk` high for 250 cycles → `busy` falls, `frame_err`=1. The next full `4D` frame decodes correctly.
- Assert `rst` for 1 cycle after bit 6 of a frame, with 2 events buffered → all outputs 0 next cycle. Resuming mid-frame bits yields no event.
